// File: rtl/lane_sum_accum_if.sv
// Valid/ready bus between a packed-lane producer, lane_sum_accum and its result consumer.
interface lane_sum_accum_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 4,
  parameter int unsigned CNT_W  = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LANE_W-1:0]   in_data;
  logic                      in_last;
  logic                      in_sat;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANE_W-1:0]         out_sum;
  logic                      out_ovf;
  logic [CNT_W-1:0]          out_beats;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_last, in_sat, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, out_beats
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_last, in_sat, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, out_beats
  );
endinterface

// File: rtl/lane_sum_accum.sv
// Sums every lane of every beat in a frame into one LANE_W-bit result,
// wrapping or saturating per frame, with a sticky overflow flag and beat count.
module lane_sum_accum #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned LANE_W = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lane_sum_accum_if.slave bus
);

  // Wide enough for acc plus a full beat of all-ones lanes
  localparam int unsigned SUM_W = LANE_W + $clog2(LANES) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;

  logic                r_mode;
  logic [LANE_W-1:0]   r_acc;
  logic                r_ovf;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_out_valid;
  logic [LANE_W-1:0]   r_out_sum;
  logic                r_out_ovf;
  logic [CNT_W-1:0]    r_out_beats;

  logic                w_in_ready;
  logic                w_accept;
  logic                w_consume;
  logic                w_mode_eff;
  logic [LANE_W-1:0]   w_lane [LANES];
  logic [SUM_W-1:0]    w_bsum;
  logic [SUM_W-1:0]    w_nxt;
  logic                w_ovf_b;
  logic [LANE_W-1:0]   w_acc_nxt;
  logic                w_ovf_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;

  // Handshake decode; a held result blocks input unless it is consumed this cycle
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_consume  = r_out_valid && bus.out_ready;

  // First beat of a frame uses in_sat directly; later beats use the latched mode
  assign w_mode_eff = (r_state == ST_IDLE) ? bus.in_sat : r_mode;

  // Unpack lanes
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane[g] = bus.in_data[g*LANE_W +: LANE_W];
  end

  // Beat sum across all lanes
  always_comb begin
    w_bsum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_bsum = w_bsum + SUM_W'(w_lane[k]);
    end
  end

  // Post-beat accumulator, overflow and count values
  assign w_nxt     = SUM_W'(r_acc) + w_bsum;
  assign w_ovf_b   = |w_nxt[SUM_W-1:LANE_W];
  assign w_acc_nxt = (w_mode_eff && w_ovf_b) ? {LANE_W{1'b1}} : w_nxt[LANE_W-1:0];
  assign w_ovf_nxt = r_ovf | w_ovf_b;
  assign w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and result-load strobe
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    if (w_accept) begin
      if (bus.in_last) begin
        w_load      = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_ACCUM;
      end
    end
  end

  // Frame accumulator, latched mode and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_beats <= '0;
    end else begin
      if (w_accept && (r_state == ST_IDLE)) begin
        r_mode <= bus.in_sat;
      end
      if (w_load) begin
        r_acc       <= '0;
        r_ovf       <= 1'b0;
        r_cnt       <= '0;
        r_out_sum   <= w_acc_nxt;
        r_out_ovf   <= w_ovf_nxt;
        r_out_beats <= w_cnt_nxt;
        r_out_valid <= 1'b1;
      end else begin
        if (w_accept) begin
          r_acc <= w_acc_nxt;
          r_ovf <= w_ovf_nxt;
          r_cnt <= w_cnt_nxt;
        end
        if (w_consume) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_beats = r_out_beats;

endmodule

// File: tb/tb_lane_sum_accum.sv
// Directed bench for lane_sum_accum with LANES=2, LANE_W=4, CNT_W=8.
module tb_lane_sum_accum;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  lane_sum_accum_if #(.LANES(2), .LANE_W(4), .CNT_W(8)) u_if ();

  lane_sum_accum #(.LANES(2), .LANE_W(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, landing 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [7:0] d, input logic last, input logic sat);
    int unsigned waited;
    waited = 0;
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    u_if.in_last  = last;
    u_if.in_sat   = sat;
    while (!u_if.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!u_if.in_ready) check("beat_accept_timeout", 32'(u_if.in_ready), 32'd1);
    tick();
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    u_if.in_data  = 8'hA5;
    u_if.in_sat   = ~sat;
  endtask

  // Check the held result, then consume it
  task automatic expect_result(input string tag, input logic [3:0] sum, input logic ovf,
                               input logic [7:0] beats);
    check({tag, "_valid"}, 32'(u_if.out_valid), 32'd1);
    check({tag, "_sum"},   32'(u_if.out_sum),   32'(sum));
    check({tag, "_ovf"},   32'(u_if.out_ovf),   32'(ovf));
    check({tag, "_beats"}, 32'(u_if.out_beats), 32'(beats));
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(u_if.out_valid), 32'd0);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ref_s;
    logic [3:0] ref_sum;
    logic       ref_ovf;
    n_checks = 0;
    n_fail   = 0;
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_last   = 1'b0;
    u_if.in_sat    = 1'b0;
    u_if.out_ready = 1'b0;
    rst_n = 1'b0;
    #23;

    // Reset state
    check("rst_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_sum",   32'(u_if.out_sum),   32'd0);
    check("rst_ovf",   32'(u_if.out_ovf),   32'd0);
    check("rst_beats", 32'(u_if.out_beats), 32'd0);
    check("rst_ready", 32'(u_if.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single-beat frames
    send_beat(8'h35, 1'b1, 1'b0);
    expect_result("wrap_35", 4'h8, 1'b0, 8'd1);
    send_beat(8'hF1, 1'b1, 1'b0);
    expect_result("wrap_F1", 4'h0, 1'b1, 8'd1);
    send_beat(8'hF1, 1'b1, 1'b1);
    expect_result("sat_F1", 4'hF, 1'b1, 8'd1);

    // Multi-beat frame, in_sat toggled mid-frame
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b1);
    send_beat(8'h03, 1'b1, 1'b1);
    expect_result("multi", 4'h9, 1'b0, 8'd3);

    // Wrap frame: in_sat=1 on later beats must not saturate (E+2 wraps to 0)
    send_beat(8'hFF, 1'b0, 1'b0);
    send_beat(8'h11, 1'b1, 1'b1);
    expect_result("wrap_lock", 4'h0, 1'b1, 8'd2);

    // Sat frame: stays all-ones after adding zeros, in_sat=0 later is ignored
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'h00, 1'b0, 1'b0);
    send_beat(8'h01, 1'b1, 1'b0);
    expect_result("sat_lock", 4'hF, 1'b1, 8'd3);

    // Backpressure with result 9 pending
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h03, 1'b1, 1'b0);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h44;
    u_if.in_last  = 1'b1;
    u_if.in_sat   = 1'b0;
    #1;
    check("bp_ready_low", 32'(u_if.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_hold", 32'(u_if.out_valid), 32'd1);
      check("bp_sum_hold",   32'(u_if.out_sum),   32'd9);
      check("bp_beats_hold", 32'(u_if.out_beats), 32'd3);
      check("bp_ready_hold", 32'(u_if.in_ready),  32'd0);
    end
    u_if.out_ready = 1'b1;
    #1;
    check("bp_ready_pass", 32'(u_if.in_ready), 32'd1);
    tick();
    u_if.out_ready = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_last   = 1'b0;
    expect_result("bp_reload", 4'h8, 1'b0, 8'd1);

    // Reset while a result is held: out_valid drops without a clock edge
    send_beat(8'h35, 1'b1, 1'b0);
    check("hold_before_rst", 32'(u_if.out_valid), 32'd1);
    rst_n = 1'b0;
    #2;
    check("rst_held_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_held_sum",   32'(u_if.out_sum),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-frame discards the partial sum
    send_beat(8'h77, 1'b0, 1'b0);
    send_beat(8'h77, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("rst_mid_valid", 32'(u_if.out_valid), 32'd0);
    check("rst_mid_beats", 32'(u_if.out_beats), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_beat(8'h12, 1'b1, 1'b0);
    expect_result("after_rst", 4'h3, 1'b0, 8'd1);

    // Beat counter saturates at 255 over a 300-beat zero frame
    for (int i = 0; i < 299; i++) send_beat(8'h00, 1'b0, 1'b0);
    send_beat(8'h00, 1'b1, 1'b0);
    expect_result("cnt_sat", 4'h0, 1'b0, 8'd255);

    // Sweep all single-beat inputs in both modes
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 256; d++) begin
        ref_s   = 5'(d % 16) + 5'(d / 16);
        ref_ovf = (ref_s > 5'd15);
        ref_sum = (m == 1 && ref_ovf) ? 4'hF : ref_s[3:0];
        send_beat(8'(d), 1'b1, 1'(m));
        expect_result(m == 1 ? "sweep_sat" : "sweep_wrap", ref_sum, ref_ovf, 8'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
